// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 constants: exception codes, register numbers, field positions
// and the handler entry point.
package cp0_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE   = 32'h0040_0001;

  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IM_LO      = 10;
  localparam int unsigned SR_IM_HI      = 15;
  localparam int unsigned CAUSE_EXC_LO  = 2;
  localparam int unsigned CAUSE_EXC_HI  = 6;
  localparam int unsigned CAUSE_IP_LO   = 10;
  localparam int unsigned CAUSE_IP_HI   = 15;
  localparam int unsigned CAUSE_BD_BIT  = 31;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } cp0_state_e;

  // Restart address: a delay-slot instruction resumes at its branch.
  function automatic logic [31:0] epc_from_pc(input logic [31:0] pc, input logic bd);
    logic [31:0] target;
    target = bd ? (pc - 32'd4) : pc;
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception/interrupt controller: SR, Cause, EPC, PRId and
// the NORMAL/HANDLER state machine that drives the pipeline flush request.
module cp0_ctrl
  import cp0_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic        M_BD,
  input  logic [4:0]  M_ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        M_CP0_WE,
  input  logic [4:0]  M_CP0_Addr,
  input  logic [31:0] M_CP0_WD,
  input  logic        M_Eret,
  output logic        Req,
  output logic [31:0] CP0_RD,
  output logic [31:0] EPC_O,
  output logic [31:0] Handler_PC
);

  cp0_state_e  state, state_next;
  logic [5:0]  im;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        exl;
  logic        int_req;
  logic        exc_req;
  logic        wr_en;
  logic [31:0] sr_value;
  logic [31:0] cause_value;

  assign exl     = (state == ST_HANDLER);
  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (M_ExcCode != EXC_INT) & ~exl;
  assign Req     = int_req | exc_req;
  assign wr_en   = M_CP0_WE & ~Req;

  assign sr_value    = {16'b0, im, 8'b0, exl, ie};
  assign cause_value = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

  assign EPC_O      = epc;
  assign Handler_PC = HANDLER_ADDR;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_NORMAL;
    else       state <= state_next;
  end

  // EXL is the state itself; eret wins over a same-cycle mtc0 to SR.
  always_comb begin
    state_next = state;
    if (Req) begin
      state_next = ST_HANDLER;
    end else begin
      if (wr_en && (M_CP0_Addr == CP0_SR))
        state_next = M_CP0_WD[SR_EXL_BIT] ? ST_HANDLER : ST_NORMAL;
      if (M_Eret)
        state_next = ST_NORMAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        bd       <= M_BD;
        exc_code <= int_req ? EXC_INT : M_ExcCode;
        epc      <= epc_from_pc(M_PC, M_BD);
      end else if (wr_en) begin
        case (M_CP0_Addr)
          CP0_SR: begin
            im <= M_CP0_WD[SR_IM_HI:SR_IM_LO];
            ie <= M_CP0_WD[SR_IE_BIT];
          end
          CP0_EPC: epc <= {M_CP0_WD[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    CP0_RD = '0;
    case (M_CP0_Addr)
      CP0_SR:    CP0_RD = sr_value;
      CP0_CAUSE: CP0_RD = cause_value;
      CP0_EPC:   CP0_RD = epc;
      CP0_PRID:  CP0_RD = PRID_VALUE;
      default:   CP0_RD = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed self-checking bench for cp0_ctrl.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_PC;
  logic        M_BD;
  logic [4:0]  M_ExcCode;
  logic [5:0]  HWInt;
  logic        M_CP0_WE;
  logic [4:0]  M_CP0_Addr;
  logic [31:0] M_CP0_WD;
  logic        M_Eret;
  logic        Req;
  logic [31:0] CP0_RD;
  logic [31:0] EPC_O;
  logic [31:0] Handler_PC;

  int checks = 0;
  int errors = 0;

  cp0_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .M_PC       (M_PC),
    .M_BD       (M_BD),
    .M_ExcCode  (M_ExcCode),
    .HWInt      (HWInt),
    .M_CP0_WE   (M_CP0_WE),
    .M_CP0_Addr (M_CP0_Addr),
    .M_CP0_WD   (M_CP0_WD),
    .M_Eret     (M_Eret),
    .Req        (Req),
    .CP0_RD     (CP0_RD),
    .EPC_O      (EPC_O),
    .Handler_PC (Handler_PC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset      = 1'b0;
    M_PC       = 32'h0;
    M_BD       = 1'b0;
    M_ExcCode  = 5'd0;
    M_CP0_WE   = 1'b0;
    M_CP0_Addr = 5'd0;
    M_CP0_WD   = 32'h0;
    M_Eret     = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
    M_CP0_Addr = addr;
    #1;
    chk(tag, CP0_RD, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] wd);
    M_CP0_WE   = 1'b1;
    M_CP0_Addr = addr;
    M_CP0_WD   = wd;
    step();
    M_CP0_WE   = 1'b0;
  endtask

  initial begin
    idle();
    HWInt = 6'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("reset_req", {31'b0, Req}, 32'h0);
    rd(5'd12, "reset_sr", 32'h0);
    rd(5'd13, "reset_cause", 32'h0);
    rd(5'd14, "reset_epc", 32'h0);
    rd(5'd15, "prid", 32'h0040_0001);
    rd(5'd3, "unmapped_rd", 32'h0);
    chk("handler_pc", Handler_PC, 32'h0000_4180);

    // Enabled interrupt from NORMAL
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, "sr_written", 32'h0000_0401);
    HWInt = 6'b000001;
    M_PC  = 32'h3008;
    #1;
    chk("int_req_same_cycle", {31'b0, Req}, 32'h1);
    step();
    HWInt = 6'd0;
    #1;
    chk("int_req_after", {31'b0, Req}, 32'h0);
    rd(5'd14, "int_epc", 32'h3008);
    rd(5'd13, "int_cause", 32'h0000_0400);
    rd(5'd12, "int_sr_exl", 32'h0000_0403);

    // Nothing is taken while EXL=1
    M_ExcCode = 5'd10;
    HWInt     = 6'b111111;
    M_PC      = 32'h7777;
    #1;
    chk("nested_req", {31'b0, Req}, 32'h0);
    step();
    M_ExcCode = 5'd0;
    rd(5'd14, "nested_epc", 32'h3008);
    rd(5'd13, "cause_ip_follow", 32'h0000_FC00);
    HWInt = 6'b000001;

    // eret with an enabled interrupt still pending
    mtc0(5'd14, 32'h3020);
    M_Eret = 1'b1;
    #1;
    chk("eret_epc_o", EPC_O, 32'h3020);
    chk("eret_req", {31'b0, Req}, 32'h0);
    step();
    M_Eret = 1'b0;
    M_PC   = 32'h4000;
    rd(5'd12, "eret_sr", 32'h0000_0401);
    chk("pending_int_req", {31'b0, Req}, 32'h1);
    step();
    HWInt = 6'd0;
    rd(5'd14, "pending_int_epc", 32'h4000);

    // Overflow in a delay slot with interrupts masked
    mtc0(5'd12, 32'h0);
    rd(5'd12, "sr_cleared", 32'h0);
    M_ExcCode = 5'd12;
    M_BD      = 1'b1;
    M_PC      = 32'h3010;
    #1;
    chk("ov_req", {31'b0, Req}, 32'h1);
    step();
    M_ExcCode = 5'd0;
    M_BD      = 1'b0;
    rd(5'd14, "ov_epc", 32'h300C);
    rd(5'd13, "ov_cause", 32'h8000_0030);
    rd(5'd12, "ov_sr", 32'h0000_0002);

    // mtc0 EPC dropped under a simultaneous exception, then retried
    M_Eret = 1'b1;
    step();
    M_Eret = 1'b0;
    M_ExcCode  = 5'd4;
    M_PC       = 32'h5006;
    M_CP0_WE   = 1'b1;
    M_CP0_Addr = 5'd14;
    M_CP0_WD   = 32'h3003;
    #1;
    chk("drop_req", {31'b0, Req}, 32'h1);
    step();
    M_CP0_WE  = 1'b0;
    M_ExcCode = 5'd0;
    rd(5'd14, "drop_epc", 32'h5004);
    rd(5'd13, "adel_cause", 32'h0000_0010);
    M_Eret = 1'b1;
    step();
    M_Eret = 1'b0;
    mtc0(5'd14, 32'h3003);
    rd(5'd14, "retry_epc", 32'h3000);

    // Delay-slot PC of zero wraps
    M_ExcCode = 5'd5;
    M_BD      = 1'b1;
    M_PC      = 32'h0;
    step();
    M_ExcCode = 5'd0;
    M_BD      = 1'b0;
    rd(5'd14, "wrap_epc", 32'hFFFF_FFFC);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_readonly", 32'h8000_0014);

    // Interrupt wins over a simultaneous exception
    mtc0(5'd12, 32'h0000_0401);
    HWInt     = 6'b000001;
    M_ExcCode = 5'd12;
    M_PC      = 32'h6000;
    #1;
    chk("prio_req", {31'b0, Req}, 32'h1);
    step();
    M_ExcCode = 5'd0;
    rd(5'd13, "prio_cause", 32'h0000_0400);

    // Reset in HANDLER with an interrupt asserted and a pending mtc0
    reset      = 1'b1;
    M_CP0_WE   = 1'b1;
    M_CP0_Addr = 5'd14;
    M_CP0_WD   = 32'h1234;
    M_Eret     = 1'b1;
    step();
    reset    = 1'b0;
    M_CP0_WE = 1'b0;
    M_Eret   = 1'b0;
    #1;
    chk("rst_req", {31'b0, Req}, 32'h0);
    rd(5'd12, "rst_sr", 32'h0);
    rd(5'd13, "rst_cause", 32'h0);
    rd(5'd14, "rst_epc", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; clears state on the rising edge while high.
REQ-003 M_PC  in  32  PC of the instruction in M stage.
REQ-004 M_BD  in  1  M instruction is in a branch delay slot.
REQ-005 M_ExcCode  in  5  exception code of the M instruction; 0 = none.
REQ-006 HWInt  in  6  external interrupt lines, level-sensitive.
REQ-007 M_CP0_WE  in  1  mtc0 in M stage.
REQ-008 M_CP0_Addr  in  5  CP0 register number for mtc0/mfc0.
REQ-009 M_CP0_WD  in  32  mtc0 write data.
REQ-010 M_Eret  in  1  eret in M stage.
REQ-011 Req  out  1  take exception/interrupt this cycle; kills M writeback and flushes the pipe.
REQ-012 CP0_RD  out  32  combinational read of M_CP0_Addr.
REQ-013 EPC_O  out  32  current EPC register, the eret target.
REQ-014 Handler_PC  out  32  constant 32'h0000_4180.

Function
REQ-015 SR (reg 12) SHALL hold IM[15:10], EXL[1] and IE[0]; all other bits read 0.
REQ-016 Cause (reg 13) SHALL hold BD[31], IP[15:10] and ExcCode[6:2]; all other bits read 0; it is read-only to mtc0.
REQ-017 Cause.IP SHALL load HWInt every cycle, independent of Req or writes.
REQ-018 IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL; ExcReq = (M_ExcCode != 0) & !SR.EXL; Req = IntReq | ExcReq, combinational, same cycle.
REQ-019 State machine: NORMAL (EXL=0) and HANDLER (EXL=1).
REQ-020 NORMAL->HANDLER on Req; HANDLER->NORMAL on M_Eret; writing SR.EXL via mtc0 also moves state.
REQ-021 On Req, next edge: EXL<=1; Cause.BD<=M_BD; EPC<={(M_BD ? M_PC-4 : M_PC)[31:2],2'b00}.
REQ-022 On Req, Cause.ExcCode<=0 if IntReq, else M_ExcCode; an interrupt has priority over a simultaneous exception.
REQ-023 mtc0 SHALL commit only when M_CP0_WE & !Req; if Req is high in the same cycle, the write is dropped.
REQ-024 mtc0 to reg 12 writes IM/EXL/IE; reg 14 writes EPC with [1:0] forced 0; other addresses are ignored.
REQ-025 M_Eret & !Req SHALL clear EXL at the next edge; EPC_O is valid in the same cycle as M_Eret.
REQ-026 While EXL=1, Req SHALL be 0 for all causes; nested exceptions are not taken.
REQ-027 CP0_RD decode: 12 SR, 13 Cause, 14 EPC, 15 PRId constant; any other address returns 0.
REQ-028 CP0_RD returns register contents before any same-cycle update; there is no bypass.
REQ-029 The M_PC-4 subtraction SHALL wrap modulo 2^32.

Reset
REQ-030 On reset: SR=0, Cause=0, EPC=0, state NORMAL, so Req=0 in the first cycle after reset.
REQ-031 Reset overrides Req, mtc0 and eret in the same cycle.
REQ-032 Reset asserted while in HANDLER returns the block to NORMAL with EXL=0.

Structure
REQ-033 The shared package/header SHALL define:
- ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- CP0 register numbers 12/13/14/15.
- Handler address 32'h0000_4180.
- PRId value.
- SR and Cause bit positions.
REQ-034 The block is a single module with no sub-module.

Verification
REQ-035 SR=0x0000_0401, HWInt=6'b000001, M_PC=0x3008, M_BD=0 -> Req=1 same cycle; next cycle EPC=0x3008, Cause.ExcCode=0, EXL=1.
REQ-036 M_ExcCode=12 (Ov), M_BD=1, M_PC=0x3010, SR=0 -> Req=1; EPC=0x300C, Cause.BD=1, ExcCode=12.
REQ-037 EXL=1, M_ExcCode=10, HWInt=6'b111111 -> Req=0; EPC unchanged.
REQ-038 M_CP0_WE=1, Addr=14, WD=0x3003, with Req=1 the same cycle -> EPC unchanged, set from the exception PC; retried with Req=0 -> EPC=0x3000.
REQ-039 HANDLER, EPC=0x3020, M_Eret=1 -> EPC_O=0x3020 that cycle; EXL=0 next cycle; a pending enabled interrupt raises Req the cycle after.
REQ-040 Reset high while EXL=1 and HWInt active -> SR=Cause=EPC=0 and Req=0 on the following cycle.
